nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by reusing one four_bit_rca instance, one nibble per clock, least-significant nibble first.
- Holds the inter-nibble carry in a register and drives a start/busy/done handshake.
- Sits between a requesting datapath and the shared 4-bit adder, trading latency for area.

Parameters:
- WIDTH, 16, operand and sum width; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4 (derived localparam), number of nibble steps.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; latched on an accepted start
- b  input  WIDTH  operand B; latched on an accepted start
- cin  input  1  carry-in; latched on an accepted start
- busy  output  1  high while the state is RUN
- done  output  1  one-cycle pulse when sum and cout become valid
- sum  output  WIDTH  result register
- cout  output  1  final carry-out register

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0, idx=0, carry register=0, operand registers=0. Reset takes effect immediately, including mid-RUN; the partial result is discarded.
- States:
  - IDLE: start=1 -> latch a, b, cin (carry register <= cin), idx<=0, go to RUN.
  - RUN: each cycle, drive the shared RCA with A-nibble[idx], B-nibble[idx] and the carry register. On the clock edge: sum[4*idx+3:4*idx] <= RCA S, carry <= RCA Cout, idx <= idx+1. When idx == NIB-1, also load cout <= RCA Cout and go to DONE.
  - DONE: done=1 for exactly this cycle. start=1 -> accept a new request exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: with an accepted start at edge k, busy is high for cycles k+1..k+NIB and done is high in cycle k+NIB+1. Total NIB+1 cycles from start to done.
- sum and cout hold their last value after done until the next accepted start. On an accepted start, sum is not cleared; nibbles are overwritten progressively, so sum is valid only when done=1 or afterwards.
- start while in RUN is ignored, with no queueing. Inputs a, b and cin may change freely during RUN because the block uses its latched copies.
- idx wraps only through the RUN->DONE transition and is never used out of range. With WIDTH=4, RUN lasts exactly one cycle.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1).

Optional Feature:
- Macro NSA_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), latched on an accepted start.
  - When sub=1, the B operand is latched as ~b and the carry register is initialised to 1, ignoring cin, so sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a >= b unsigned).
- When undefined: no sub port; addition only.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h4321, cin=1, one-cycle start -> busy for 4 cycles, done in cycle 5 after start, sum=16'h5556, cout=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> carry ripples through all nibbles; sum=16'h0000, cout=1. Check that sum and cout hold for 10 idle cycles afterwards.
- Start accepted, then start=1 with different a/b during RUN -> ignored. Result is for the first operands and done pulses only once.
- start held high through DONE, with new operands a=16'h00FF, b=16'h0001, cin=0 -> second operation begins without an IDLE cycle; second done gives sum=16'h0100, cout=0.
- rst asserted during the 2nd RUN cycle -> busy, done, sum and cout go to 0 immediately. After release, a new request a=16'h0003, b=16'h0004 gives sum=16'h0007.
- NSA_SUB_EN defined, sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0. Then a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit adder built from one shared 4-bit RCA, one nibble per clock, LSB nibble first.
// Optional NSA_SUB_EN adds a sub port for a - b via ~b and carry-in 1.
module four_bit_rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic carry, accept, last, rc, c_in;
  logic [WIDTH-1:0] op_a, op_b, b_in;
  logic [3:0] rs;
`ifdef NSA_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif
  four_bit_rca u_rca (
    .a (op_a[4*idx +: 4]),
    .b (op_b[4*idx +: 4]),
    .ci(carry),
    .s (rs),
    .co(rc)
  );
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    accept = start && state != RUN;
    last = idx == IW'(NIB - 1);
    state_nx = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // idx returns to zero explicitly on the last step so NIB need not be a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      cout <= 1'b0;
      carry <= 1'b0;
      idx <= '0;
      op_a <= '0;
      op_b <= '0;
    end else if (state == RUN) begin
      sum[4*idx +: 4] <= rs;
      carry <= rc;
      idx <= last ? '0 : idx + IW'(1);
      if (last) cout <= rc;
    end else if (accept) begin
      op_a <= a;
      op_b <= b_in;
      carry <= c_in;
      idx <= '0;
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: random and directed stimulus checked against an arithmetic model every cycle.
module tb_nibble_serial_adder_ctrl;
  localparam int W = 16;
  localparam int NIB = W / 4;
  logic clk = 0, rst = 1, start = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout;
`ifdef NSA_SUB_EN
  logic sub = 0;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef NSA_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: ph 0 idle, 1..NIB nibble steps pending, NIB+1 done cycle
  int ph = 0;
  logic [W:0] res;
  logic [W-1:0] old, m_sum = '0, eb;
  logic m_cout = 0, es;
  function automatic logic [63:0] mk(input int j);
    return (64'd1 << (4 * j)) - 64'd1;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0;
      m_sum = '0;
      m_cout = 0;
    end else if (ph >= 1 && ph <= NIB) begin
      m_sum = W'((64'(res[W-1:0]) & mk(ph)) | (64'(old) & ~mk(ph)));
      if (ph == NIB) m_cout = res[W];
      ph++;
    end else if (start) begin
      es = 0;
`ifdef NSA_SUB_EN
      es = sub;
`endif
      eb = es ? ~b : b;
      res = {1'b0, a} + {1'b0, eb} + (W+1)'(es | cin);
      old = m_sum;
      ph = 1;
    end else ph = 0;
  end
  always @(negedge clk)
    if (!rst) begin
      chk("busy", 64'(busy), 64'(ph >= 1 && ph <= NIB));
      chk("done", 64'(done), 64'(ph == NIB + 1));
      chk("sum", 64'(sum), 64'(m_sum));
      chk("cout", 64'(cout), 64'(m_cout));
    end
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 4 * NIB + 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input logic ts, output int n);
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tc; start = 1;
`ifdef NSA_SUB_EN
    sub = ts;
`endif
    @(posedge clk); #1;
    start = 0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef NSA_SUB_EN
    sub = 1'($urandom);
`endif
    wait_done(n);
  endtask
  int n, dn;
  initial begin
    #2;
    chk("rst_busy", 64'(busy), 0); chk("rst_done", 64'(done), 0);
    chk("rst_sum", 64'(sum), 0); chk("rst_cout", 64'(cout), 0);
    #10 @(negedge clk) rst = 0;
    do_op(16'h1234, 16'h4321, 1, 0, n);
    chk("latency", 64'(n), 64'(NIB));
    chk("t1_sum", 64'(sum), 64'h5556); chk("t1_cout", 64'(cout), 0);
    do_op(16'hFFFF, 16'h0001, 0, 0, n);
    chk("t2_sum", 64'(sum), 0); chk("t2_cout", 64'(cout), 1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_sum", 64'(sum), 0); chk("hold_cout", 64'(cout), 1);
    end
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; cin = 0; start = 1;
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h7070; cin = 1;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555;
    @(posedge clk); #1;
    start = 0;
    dn = 0;
    repeat (10) begin
      @(posedge clk); #1;
      dn += int'(done);
    end
    chk("one_done", 64'(dn), 1);
    chk("t3_sum", 64'(sum), 64'h3333); chk("t3_cout", 64'(cout), 0);
    @(posedge clk); #1;
    a = 16'h0010; b = 16'h0020; cin = 0; start = 1;
    @(posedge clk); #1;
    a = 16'h00FF; b = 16'h0001;
    wait_done(n);
    chk("b2b_first", 64'(sum), 64'h0030);
    @(posedge clk); #1;
    start = 0;
    chk("b2b_busy", 64'(busy), 1);
    wait_done(n);
    chk("b2b_sum", 64'(sum), 64'h0100); chk("b2b_cout", 64'(cout), 0);
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1111; cin = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("mid_busy", 64'(busy), 0); chk("mid_done", 64'(done), 0);
    chk("mid_sum", 64'(sum), 0); chk("mid_cout", 64'(cout), 0);
    @(negedge clk) rst = 0;
    do_op(16'h0003, 16'h0004, 0, 0, n);
    chk("post_rst_sum", 64'(sum), 64'h0007);
`ifdef NSA_SUB_EN
    do_op(16'h0005, 16'h0007, 0, 1, n);
    chk("sub1_sum", 64'(sum), 64'hFFFE); chk("sub1_cout", 64'(cout), 0);
    do_op(16'h0007, 16'h0005, 0, 1, n);
    chk("sub2_sum", 64'(sum), 64'h0002); chk("sub2_cout", 64'(cout), 1);
`endif
    repeat (40) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), n);
      chk("rnd_latency", 64'(n), 64'(NIB));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
